// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath controls and counts retired instructions.
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             cmp,
    output logic [2:0]       nPC_sel,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             ext_op,
    output logic             mem_we,
    output logic [1:0]       wd_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OpNop, OpAddu, OpSubu, OpJr, OpOri, OpLui, OpLw, OpSw, OpBeq, OpJ, OpJal
    } op_t;

    state_t           r_state, w_state_d;
    logic [CNT_W-1:0] r_retired;
    op_t              w_op;
    logic             w_pc_we, w_ir_we, w_reg_we, w_mem_we;

    // cmp is consumed by the fetch unit; the middle instruction bits only feed the datapath
    logic w_unused_bits;
    assign w_unused_bits = ^{cmp, instr[25:6]};

    always_comb begin
        w_op = OpNop;
        case (instr[31:26])
            6'b000000: begin
                case (instr[5:0])
                    6'b100001: w_op = OpAddu;
                    6'b100011: w_op = OpSubu;
                    6'b001000: w_op = OpJr;
                    default:   w_op = OpNop;
                endcase
            end
            6'b001101: w_op = OpOri;
            6'b001111: w_op = OpLui;
            6'b100011: w_op = OpLw;
            6'b101011: w_op = OpSw;
            6'b000100: w_op = OpBeq;
            6'b000010: w_op = OpJ;
            6'b000011: w_op = OpJal;
            default:   w_op = OpNop;
        endcase
    end

    always_comb begin
        w_state_d = StFetch;
        w_pc_we   = 1'b0;
        w_ir_we   = 1'b0;
        w_reg_we  = 1'b0;
        w_mem_we  = 1'b0;
        nPC_sel   = 3'd0;
        reg_dst   = 2'd0;
        alu_src   = 1'b0;
        alu_op    = 2'd0;
        ext_op    = 1'b0;
        wd_sel    = 2'd0;
        case (r_state)
            StFetch: begin
                w_ir_we   = 1'b1;
                w_state_d = StDecode;
            end
            StDecode: begin
                case (w_op)
                    OpJ: begin
                        w_pc_we = 1'b1;
                        nPC_sel = 3'd3;
                    end
                    OpJr: begin
                        w_pc_we = 1'b1;
                        nPC_sel = 3'd2;
                    end
                    OpNop:   w_pc_we   = 1'b1;
                    OpJal:   w_state_d = StWb;
                    default: w_state_d = StExec;
                endcase
            end
            StExec: begin
                case (w_op)
                    OpAddu: w_state_d = StWb;
                    OpSubu: begin
                        alu_op    = 2'd1;
                        w_state_d = StWb;
                    end
                    OpOri: begin
                        alu_src   = 1'b1;
                        alu_op    = 2'd2;
                        w_state_d = StWb;
                    end
                    OpLui: begin
                        alu_src   = 1'b1;
                        alu_op    = 2'd3;
                        w_state_d = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_src   = 1'b1;
                        ext_op    = 1'b1;
                        w_state_d = StMem;
                    end
                    OpBeq: begin
                        alu_op  = 2'd1;
                        ext_op  = 1'b1;
                        w_pc_we = 1'b1;
                        nPC_sel = 3'd1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                if (w_op == OpLw) begin
                    alu_src   = 1'b1;
                    ext_op    = 1'b1;
                    w_state_d = StWb;
                end else if (w_op == OpSw) begin
                    w_mem_we = 1'b1;
                    w_pc_we  = 1'b1;
                end
            end
            StWb: begin
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
                case (w_op)
                    OpAddu, OpSubu: reg_dst = 2'd1;
                    OpLw:           wd_sel  = 2'd1;
                    OpJal: begin
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                        nPC_sel = 3'd3;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign pc_we   = w_pc_we & reset;
    assign ir_we   = w_ir_we & reset;
    assign reg_we  = w_reg_we & reset;
    assign mem_we  = w_mem_we & reset;
    assign state   = r_state;
    assign retired = r_retired;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= StFetch;
            r_retired <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_pc_we) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: per-cycle state/enable checks for each
// instruction class, reset behaviour and counter wrap on a narrow-counter instance.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'h8C010004;
    logic        cmp = 1'b0;

    logic [2:0]  nPC_sel, state;
    logic        pc_we, ir_we, reg_we, alu_src, ext_op, mem_we;
    logic [1:0]  reg_dst, alu_op, wd_sel;
    logic [31:0] retired;

    logic [2:0]  n4_npc, n4_state;
    logic        n4_pc_we, n4_ir_we, n4_reg_we, n4_alu_src, n4_ext_op, n4_mem_we;
    logic [1:0]  n4_reg_dst, n4_alu_op, n4_wd_sel;
    logic [3:0]  n4_retired;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .cmp(cmp),
        .nPC_sel(nPC_sel), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
        .mem_we(mem_we), .wd_sel(wd_sel), .state(state), .retired(retired)
    );

    mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .instr(instr), .cmp(cmp),
        .nPC_sel(n4_npc), .pc_we(n4_pc_we), .ir_we(n4_ir_we), .reg_we(n4_reg_we),
        .reg_dst(n4_reg_dst), .alu_src(n4_alu_src), .alu_op(n4_alu_op), .ext_op(n4_ext_op),
        .mem_we(n4_mem_we), .wd_sel(n4_wd_sel), .state(n4_state), .retired(n4_retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // st_seq holds the expected state of cycle i in bits [3*i +: 3];
    // aux = {alu_src, ext_op, alu_op} expected while in EXEC.
    task automatic run_instr(input string name, input logic [31:0] ins, input logic c,
                             input int n, input logic [14:0] st_seq,
                             input logic e_reg, input logic e_mem, input logic [2:0] e_npc,
                             input logic [1:0] e_dst, input logic [1:0] e_wd,
                             input logic [3:0] aux);
        logic [2:0] st;
        logic       last;
        instr = ins;
        cmp   = c;
        #1;
        for (int i = 0; i < n; i++) begin
            st   = st_seq[3*i +: 3];
            last = (i == n - 1);
            check($sformatf("%s c%0d state", name, i), 32'(state), 32'(st));
            check($sformatf("%s c%0d ir_we", name, i), 32'(ir_we), 32'(i == 0));
            check($sformatf("%s c%0d pc_we", name, i), 32'(pc_we), 32'(last));
            check($sformatf("%s c%0d reg_we", name, i), 32'(reg_we), 32'(last & e_reg));
            check($sformatf("%s c%0d mem_we", name, i), 32'(mem_we), 32'(last & e_mem));
            if (st == 3'd2) begin
                check($sformatf("%s exec ctl", name), 32'({alu_src, ext_op, alu_op}),
                      32'(aux));
            end
            if (last) begin
                check($sformatf("%s nPC_sel", name), 32'(nPC_sel), 32'(e_npc));
                if (e_reg) begin
                    check($sformatf("%s reg_dst", name), 32'(reg_dst), 32'(e_dst));
                    check($sformatf("%s wd_sel", name), 32'(wd_sel), 32'(e_wd));
                end
            end
            tick();
        end
        exp_ret++;
        check($sformatf("%s retired", name), retired, 32'(exp_ret));
    endtask

    initial begin
        reset = 1'b0;
        instr = 32'h8C010004;
        repeat (3) tick();
        check("rst state", 32'(state), 32'd0);
        check("rst enables", 32'({pc_we, ir_we, reg_we, mem_we}), 32'd0);
        check("rst retired", retired, 32'd0);
        reset = 1'b1;
        #1;
        check("rel ir_we", 32'(ir_we), 32'd1);

        run_instr("lw", 32'h8C010004, 1'b0, 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                  1'b1, 1'b0, 3'd0, 2'd0, 2'd1, 4'b1100);
        run_instr("sw", 32'hAC010004, 1'b0, 4, {3'd0, 3'd3, 3'd2, 3'd1, 3'd0},
                  1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 4'b1100);
        run_instr("addu", 32'h00221821, 1'b0, 4, {3'd0, 3'd4, 3'd2, 3'd1, 3'd0},
                  1'b1, 1'b0, 3'd0, 2'd1, 2'd0, 4'b0000);
        run_instr("jal", 32'h0C000C00, 1'b0, 3, {3'd0, 3'd0, 3'd4, 3'd1, 3'd0},
                  1'b1, 1'b0, 3'd3, 2'd2, 2'd2, 4'b0000);
        run_instr("beq0", 32'h10220003, 1'b0, 3, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0},
                  1'b0, 1'b0, 3'd1, 2'd0, 2'd0, 4'b0101);
        run_instr("beq1", 32'h10220003, 1'b1, 3, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0},
                  1'b0, 1'b0, 3'd1, 2'd0, 2'd0, 4'b0101);
        run_instr("j", 32'h08000C00, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0},
                  1'b0, 1'b0, 3'd3, 2'd0, 2'd0, 4'b0000);
        run_instr("jr", 32'h03E00008, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0},
                  1'b0, 1'b0, 3'd2, 2'd0, 2'd0, 4'b0000);
        run_instr("unk", 32'hFC000000, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0},
                  1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 4'b0000);
        run_instr("nop", 32'h00000000, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0},
                  1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 4'b0000);
        check("n4 retired 10", 32'(n4_retired), 32'd10);

        // Abort lw in MEM: no writes while reset is low, counter cleared by reset.
        instr = 32'h8C010004;
        repeat (3) tick();
        check("abort in mem", 32'(state), 32'd3);
        reset = 1'b0;
        #1;
        check("abort enables", 32'({pc_we, ir_we, reg_we, mem_we}), 32'd0);
        check("abort retired held", retired, 32'(exp_ret));
        tick();
        check("abort state", 32'(state), 32'd0);
        check("abort retired", retired, 32'd0);
        reset = 1'b1;
        exp_ret = 0;
        #1;
        check("abort refetch", 32'(ir_we), 32'd1);

        for (int k = 0; k < 15; k++) begin
            run_instr("nopw", 32'h00000000, 1'b0, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0},
                      1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 4'b0000);
        end
        check("n4 retired 15", 32'(n4_retired), 32'd15);
        run_instr("lw_w", 32'h8C010004, 1'b0, 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                  1'b1, 1'b0, 3'd0, 2'd0, 2'd1, 4'b1100);
        check("n4 wrap 0", 32'(n4_retired), 32'd0);
        run_instr("addu_w", 32'h00221821, 1'b0, 4, {3'd0, 3'd4, 3'd2, 3'd1, 3'd0},
                  1'b1, 1'b0, 3'd0, 2'd1, 2'd0, 4'b0000);
        check("n4 wrap 1", 32'(n4_retired), 32'd1);
        check("retired 17", retired, 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
